interface_rr_bus_controller: RTL

- Shares one downstream memory-mapped request/response port among IN_COUNT upstream requesters.
- Uses round-robin arbitration with a transaction lock: a granted requester owns the downstream port until its response returns.
- Sits between core-side master adapters (instruction fetch, data, debug) and a single slave-side bus adapter in the SoC interconnect.
- One outstanding transaction at a time.

---
 rtl/interface_rr_bus_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/interface_rr_bus_controller.sv
`default_nettype none
// ============================================================================
// Module  : interface_rr_bus_controller
// Brief   : Round-robin arbiter that shares one downstream request/response
//           port among IN_COUNT requesters, one locked transaction at a time.
// Rev     : 1.0  initial release
// ============================================================================
module interface_rr_bus_controller #(
    parameter int IN_COUNT = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SEL_W    = ($clog2(IN_COUNT) < 1 ? 1 : $clog2(IN_COUNT))
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [IN_COUNT-1:0]          req_valid_i,
    output logic [IN_COUNT-1:0]          req_ready_o,
    input  logic [IN_COUNT*ADDR_W-1:0]   req_addr_i,
    input  logic [IN_COUNT-1:0]          req_we_i,
    input  logic [IN_COUNT*DATA_W-1:0]   req_wdata_i,
    output logic [IN_COUNT-1:0]          resp_valid_o,
    output logic [DATA_W-1:0]            resp_rdata_o,
    output logic                         m_req_valid_o,
    input  logic                         m_req_ready_i,
    output logic [ADDR_W-1:0]            m_addr_o,
    output logic                         m_we_o,
    output logic [DATA_W-1:0]            m_wdata_o,
    input  logic                         m_resp_valid_i,
    input  logic [DATA_W-1:0]            m_rdata_i,
    output logic [SEL_W-1:0]             grant_o,
    output logic                         busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] C_LAST_RST = SEL_W'(IN_COUNT - 1);
    localparam logic [SEL_W:0]   C_COUNT    = (SEL_W+1)'(IN_COUNT);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SEL_W-1:0]     r_last_grant;
    logic [SEL_W-1:0]     r_grant;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_we;
    logic [DATA_W-1:0]    r_wdata;
    logic [IN_COUNT-1:0]  r_resp_valid;
    logic [DATA_W-1:0]    r_resp_rdata;

    logic [SEL_W:0]       w_sum;
    logic [SEL_W-1:0]     w_idx;
    logic [SEL_W-1:0]     w_pick;
    logic                 w_any;
    logic                 w_accept;
    logic                 w_resp_evt;
    logic [IN_COUNT-1:0]  w_pick_onehot;
    logic [IN_COUNT-1:0]  w_grant_onehot;

    // Scan last+1, last+2, ... with an explicit wrap so that IN_COUNT need
    // not be a power of two; the extra bit in w_sum holds the carry.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_sum  = '0;
        w_idx  = '0;
        for (int i = 1; i <= IN_COUNT; i++) begin
            w_sum = {1'b0, r_last_grant} + (SEL_W+1)'(i);
            if (w_sum >= C_COUNT) begin
                w_sum = w_sum - C_COUNT;
            end
            w_idx = w_sum[SEL_W-1:0];
            if (!w_any && req_valid_i[w_idx]) begin
                w_pick = w_idx;
                w_any  = 1'b1;
            end
        end
    end

    assign w_pick_onehot  = IN_COUNT'(1) << w_pick;
    assign w_grant_onehot = IN_COUNT'(1) << r_grant;

    always_comb begin
        w_state_nxt   = r_state;
        req_ready_o   = '0;
        m_req_valid_o = 1'b0;
        w_accept      = 1'b0;
        w_resp_evt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    req_ready_o = w_pick_onehot;
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_req_valid_o = 1'b1;
                if (m_req_ready_i) begin
                    // A slave may answer in the accept cycle itself.
                    if (m_resp_valid_i) begin
                        w_resp_evt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (m_resp_valid_i) begin
                    w_resp_evt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= C_LAST_RST;
            r_grant      <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= w_resp_evt ? w_grant_onehot : '0;
            if (w_resp_evt) begin
                r_resp_rdata <= m_rdata_i;
            end
            if (w_accept) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
                r_addr       <= req_addr_i[w_pick*ADDR_W +: ADDR_W];
                r_we         <= req_we_i[w_pick];
                r_wdata      <= req_wdata_i[w_pick*DATA_W +: DATA_W];
            end
        end
    end

    assign resp_valid_o = r_resp_valid;
    assign resp_rdata_o = r_resp_rdata;
    assign m_addr_o     = r_addr;
    assign m_we_o       = r_we;
    assign m_wdata_o    = r_wdata;
    assign grant_o      = r_grant;
    assign busy_o       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
